// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit -- instruction-fetch stage with IF/ID pipeline register.
//
// Keeps a 9-bit byte PC, issues requests to instruction memory, and loads
// the IF/ID register with {pc, instruction}. Supports variable memory
// latency (imem_valid), hazard stalls through a one-entry skid buffer,
// flushes, and branch redirects. A redirect that arrives while a request is
// still outstanding sets a drop flag, so the stale response is discarded.
//
// Optional feature macro: FETCH_PERF_EN adds saturating 16-bit counters
// perf_fetched and perf_stalled.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   imem_req/addr    instruction-memory request and byte address
//   imem_rdata/valid returned instruction word and its valid strobe
//   stall            hold PC and IF/ID
//   flush            replace IF/ID with a bubble
//   branch_taken/branch_target   fetch redirect
//   ifid_curr_pc/curr_instr/valid   IF/ID register contents
//   perf_fetched/perf_stalled       (FETCH_PERF_EN only) event counters
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [8:0]  RESET_PC  = 9'h000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [8:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [8:0]  branch_target,
  output logic [8:0]  ifid_curr_pc,
  output logic [31:0] ifid_curr_instr,
  output logic        ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_stalled
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [8:0]  pc, pc_n;
  logic [8:0]  skid_pc, skid_pc_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic        drop, drop_n;
  logic [8:0]  ifid_pc_n;
  logic [31:0] ifid_instr_n;
  logic        ifid_valid_n;
  logic        req_active;
  logic        accept;
  logic [8:0]  acc_pc;
  logic [31:0] acc_instr;
  logic        load_valid;

  assign req_active = (state == REQ) || (state == WAIT);
  assign imem_req   = req_active;
  assign imem_addr  = pc;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    skid_pc_n    = skid_pc;
    skid_instr_n = skid_instr;
    drop_n       = drop;
    ifid_pc_n    = ifid_curr_pc;
    ifid_instr_n = ifid_curr_instr;
    ifid_valid_n = ifid_valid;
    accept       = 1'b0;
    acc_pc       = pc;
    acc_instr    = imem_rdata;
    load_valid   = 1'b0;

    case (state)
      IDLE: state_n = REQ;  // any imem_valid here belongs to no request
      REQ, WAIT: begin
        if (drop) begin
          // Waiting out the response to a request abandoned by a redirect.
          if (imem_valid) begin
            drop_n  = 1'b0;
            state_n = REQ;
          end else begin
            state_n = WAIT;
          end
        end else if (!imem_valid) begin
          state_n = WAIT;
        end else if (stall) begin
          skid_pc_n    = pc;
          skid_instr_n = imem_rdata;
          state_n      = HOLD;
        end else begin
          accept  = 1'b1;
          state_n = REQ;
        end
      end
      HOLD: begin
        if (!stall) begin
          accept    = 1'b1;
          acc_pc    = skid_pc;
          acc_instr = skid_instr;
          state_n   = REQ;
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      if (flush) begin
        // The accepted word is discarded; PC stays so it is refetched.
        ifid_pc_n    = pc;
        ifid_instr_n = NOP_INSTR;
        ifid_valid_n = 1'b0;
      end else begin
        ifid_pc_n    = acc_pc;
        ifid_instr_n = acc_instr;
        ifid_valid_n = 1'b1;
        pc_n         = pc + 9'd4;
        load_valid   = 1'b1;
      end
    end else if (flush && !stall) begin
      ifid_pc_n    = pc;
      ifid_instr_n = NOP_INSTR;
      ifid_valid_n = 1'b0;
    end

    // A redirect wins over stall and flush.
    if (branch_taken) begin
      pc_n         = {branch_target[8:2], 2'b00};
      ifid_pc_n    = pc;
      ifid_instr_n = NOP_INSTR;
      ifid_valid_n = 1'b0;
      skid_pc_n    = 9'd0;
      skid_instr_n = NOP_INSTR;
      state_n      = REQ;
      // Still outstanding after this cycle only if no response arrived now.
      drop_n       = req_active && !imem_valid;
      load_valid   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      skid_pc         <= 9'd0;
      skid_instr      <= NOP_INSTR;
      drop            <= 1'b0;
      ifid_curr_pc    <= 9'd0;
      ifid_curr_instr <= NOP_INSTR;
      ifid_valid      <= 1'b0;
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      skid_pc         <= skid_pc_n;
      skid_instr      <= skid_instr_n;
      drop            <= drop_n;
      ifid_curr_pc    <= ifid_pc_n;
      ifid_curr_instr <= ifid_instr_n;
      ifid_valid      <= ifid_valid_n;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= 16'd0;
      perf_stalled <= 16'd0;
    end else begin
      if (load_valid && (perf_fetched != 16'hFFFF))
        perf_fetched <= perf_fetched + 16'd1;
      if (stall && (perf_stalled != 16'hFFFF))
        perf_stalled <= perf_stalled + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit -- self-checking bench for if_fetch_unit.
// Instruction memory returns a word derived from the address the same cycle.
// A vector table covers streaming, wait states, stall/skid, flush, branches,
// dropped responses and PC wrap; hand sequences cover asynchronous reset
// during a request, and a scoreboard checks a random-latency stream.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [8:0]  branch_target;
  logic [8:0]  ifid_curr_pc;
  logic [31:0] ifid_curr_instr;
  logic        ifid_valid;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stalled;
`endif

  int errors = 0;
  int checks = 0;

  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_valid      (imem_valid),
    .stall           (stall),
    .flush           (flush),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .ifid_curr_pc    (ifid_curr_pc),
    .ifid_curr_instr (ifid_curr_instr),
    .ifid_valid      (ifid_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stalled    (perf_stalled)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [8:0] a);
    return {16'hC0DE, 7'h00, a};
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v, s, f, b;
    logic [8:0]  tgt;
    logic        req;
    logic [8:0]  addr;
    logic [8:0]  ipc;
    logic        chk_pc;
    logic [31:0] instr;
    logic        ivalid;
  } vec_t;

  function automatic vec_t mk(input logic v, s, f, b, input logic [8:0] tgt,
                              input logic req, input logic [8:0] addr,
                              input logic [8:0] ipc, input logic chk_pc,
                              input logic [31:0] instr, input logic ivalid);
    vec_t r;
    r.v = v; r.s = s; r.f = f; r.b = b; r.tgt = tgt;
    r.req = req; r.addr = addr; r.ipc = ipc; r.chk_pc = chk_pc;
    r.instr = instr; r.ivalid = ivalid;
    return r;
  endfunction

  vec_t vecs[27];
  logic [8:0] sb_q[$];

  initial begin
    logic [8:0] exp_pc;
    logic [8:0] got_pc;
    logic       v;

    //           v  s  f  b  tgt     req addr    ipc     cpc instr           ivalid
    vecs[0]  = mk(1, 0, 0, 0, 9'h000, 1, 9'h000, 9'h000, 1, NOP,             0);
    vecs[1]  = mk(1, 0, 0, 0, 9'h000, 1, 9'h004, 9'h000, 1, instr_of(9'h000), 1);
    vecs[2]  = mk(1, 0, 0, 0, 9'h000, 1, 9'h008, 9'h004, 1, instr_of(9'h004), 1);
    vecs[3]  = mk(1, 0, 0, 0, 9'h000, 1, 9'h00C, 9'h008, 1, instr_of(9'h008), 1);
    vecs[4]  = mk(0, 0, 0, 0, 9'h000, 1, 9'h00C, 9'h008, 1, instr_of(9'h008), 1);
    vecs[5]  = mk(1, 0, 0, 0, 9'h000, 1, 9'h010, 9'h00C, 1, instr_of(9'h00C), 1);
    vecs[6]  = mk(0, 0, 0, 0, 9'h000, 1, 9'h010, 9'h00C, 1, instr_of(9'h00C), 1);
    vecs[7]  = mk(0, 0, 0, 0, 9'h000, 1, 9'h010, 9'h00C, 1, instr_of(9'h00C), 1);
    vecs[8]  = mk(0, 0, 0, 0, 9'h000, 1, 9'h010, 9'h00C, 1, instr_of(9'h00C), 1);
    vecs[9]  = mk(1, 0, 0, 0, 9'h000, 1, 9'h014, 9'h010, 1, instr_of(9'h010), 1);
    vecs[10] = mk(1, 0, 0, 0, 9'h000, 1, 9'h018, 9'h014, 1, instr_of(9'h014), 1);
    vecs[11] = mk(1, 0, 0, 0, 9'h000, 1, 9'h01C, 9'h018, 1, instr_of(9'h018), 1);
    vecs[12] = mk(1, 0, 0, 0, 9'h000, 1, 9'h020, 9'h01C, 1, instr_of(9'h01C), 1);
    vecs[13] = mk(1, 1, 0, 0, 9'h000, 0, 9'h020, 9'h01C, 1, instr_of(9'h01C), 1);
    vecs[14] = mk(1, 1, 0, 0, 9'h000, 0, 9'h020, 9'h01C, 1, instr_of(9'h01C), 1);
    vecs[15] = mk(1, 0, 0, 0, 9'h000, 1, 9'h024, 9'h020, 1, instr_of(9'h020), 1);
    vecs[16] = mk(1, 0, 0, 0, 9'h000, 1, 9'h028, 9'h024, 1, instr_of(9'h024), 1);
    vecs[17] = mk(1, 0, 1, 0, 9'h000, 1, 9'h028, 9'h000, 0, NOP,             0);
    vecs[18] = mk(1, 0, 0, 0, 9'h000, 1, 9'h02C, 9'h028, 1, instr_of(9'h028), 1);
    vecs[19] = mk(1, 1, 0, 1, 9'h0A6, 1, 9'h0A4, 9'h02C, 1, NOP,             0);
    vecs[20] = mk(1, 0, 0, 0, 9'h000, 1, 9'h0A8, 9'h0A4, 1, instr_of(9'h0A4), 1);
    vecs[21] = mk(0, 0, 0, 1, 9'h100, 1, 9'h100, 9'h0A8, 1, NOP,             0);
    vecs[22] = mk(1, 0, 0, 0, 9'h000, 1, 9'h100, 9'h0A8, 1, NOP,             0);
    vecs[23] = mk(1, 0, 0, 0, 9'h000, 1, 9'h104, 9'h100, 1, instr_of(9'h100), 1);
    vecs[24] = mk(1, 0, 0, 1, 9'h1FC, 1, 9'h1FC, 9'h104, 1, NOP,             0);
    vecs[25] = mk(1, 0, 0, 0, 9'h000, 1, 9'h000, 9'h1FC, 1, instr_of(9'h1FC), 1);
    vecs[26] = mk(0, 0, 0, 0, 9'h000, 1, 9'h000, 9'h1FC, 1, instr_of(9'h1FC), 1);

    reset = 1'b1; imem_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = 9'h000;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst imem_req",   {31'd0, imem_req},   32'd0);
    check("rst imem_addr",  {23'd0, imem_addr},  32'h000);
    check("rst ifid_pc",    {23'd0, ifid_curr_pc}, 32'h000);
    check("rst ifid_instr", ifid_curr_instr,     NOP);
    check("rst ifid_valid", {31'd0, ifid_valid}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 27; i++) begin
      imem_valid    = vecs[i].v;
      stall         = vecs[i].s;
      flush         = vecs[i].f;
      branch_taken  = vecs[i].b;
      branch_target = vecs[i].tgt;
      @(posedge clk);
      #1;
      check($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].req});
      if (vecs[i].req)
        check($sformatf("v%0d imem_addr", i), {23'd0, imem_addr}, {23'd0, vecs[i].addr});
      if (vecs[i].chk_pc)
        check($sformatf("v%0d ifid_pc", i), {23'd0, ifid_curr_pc}, {23'd0, vecs[i].ipc});
      check($sformatf("v%0d ifid_instr", i), ifid_curr_instr, vecs[i].instr);
      check($sformatf("v%0d ifid_valid", i), {31'd0, ifid_valid}, {31'd0, vecs[i].ivalid});
      @(negedge clk);
    end
    imem_valid = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;

    // Reset asserted while waiting on memory: immediate effect, late response ignored.
    reset = 1'b0;
    imem_valid = 1'b1;
    #1;
    check("async imem_req",   {31'd0, imem_req},     32'd0);
    check("async imem_addr",  {23'd0, imem_addr},    32'h000);
    check("async ifid_pc",    {23'd0, ifid_curr_pc}, 32'h000);
    check("async ifid_instr", ifid_curr_instr,       NOP);
    check("async ifid_valid", {31'd0, ifid_valid},   32'd0);
    @(posedge clk); #1;
    check("inrst imem_req",   {31'd0, imem_req},     32'd0);
    check("inrst ifid_valid", {31'd0, ifid_valid},   32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("restart imem_addr",  {23'd0, imem_addr}, 32'h000);
    check("restart ifid_instr", ifid_curr_instr,    NOP);
    check("restart ifid_valid", {31'd0, ifid_valid}, 32'd0);
    @(posedge clk); #1;
    check("restart2 ifid_pc",    {23'd0, ifid_curr_pc}, 32'h000);
    check("restart2 ifid_instr", ifid_curr_instr,       instr_of(9'h000));
    check("restart2 imem_addr",  {23'd0, imem_addr},    32'h004);

    // Random-latency stream through the scoreboard.
    exp_pc = 9'h004;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      check($sformatf("sb%0d imem_addr", c), {23'd0, imem_addr}, {23'd0, exp_pc});
      v = 1'($urandom_range(0, 1));
      imem_valid = v;
      if (v) begin
        sb_q.push_back(exp_pc);
        exp_pc = exp_pc + 9'd4;
      end
      @(posedge clk); #1;
      if (v) begin
        got_pc = sb_q.pop_front();
        check($sformatf("sb%0d ifid_pc", c),    {23'd0, ifid_curr_pc}, {23'd0, got_pc});
        check($sformatf("sb%0d ifid_instr", c), ifid_curr_instr,       instr_of(got_pc));
        check($sformatf("sb%0d ifid_valid", c), {31'd0, ifid_valid},   32'd1);
      end
    end
    check("sb queue empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 9'h000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, giving the bubble encoding (addi x0,x0,0).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-005 The block SHALL have port imem_req, output, 1 bit: instruction-memory request.
REQ-006 The block SHALL have port imem_addr, output, 9 bits: byte address of the request.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: returned instruction word.
REQ-008 The block SHALL have port imem_valid, input, 1 bit: imem_rdata is valid for the current request.
REQ-009 The block SHALL have port stall, input, 1 bit: hold the PC and the IF/ID register (hazard unit).
REQ-010 The block SHALL have port flush, input, 1 bit: replace IF/ID contents with a bubble.
REQ-011 The block SHALL have port branch_taken, input, 1 bit: redirect fetch.
REQ-012 The block SHALL have port branch_target, input, 9 bits: redirect byte address.
REQ-013 The block SHALL have port ifid_curr_pc, output, 9 bits: IF/ID Curr_Pc field.
REQ-014 The block SHALL have port ifid_curr_instr, output, 32 bits: IF/ID Curr_Instr field.
REQ-015 The block SHALL have port ifid_valid, output, 1 bit: IF/ID holds a real instruction.

Function
REQ-016 The block SHALL keep a 9-bit PC; increment by 4 wraps modulo 512 (9'h1FC -> 9'h000).
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and HOLD; IDLE -> REQ unconditionally on the first clock after reset release.
REQ-018 The block SHALL assert imem_req with imem_addr=PC in REQ and WAIT, and deassert it in IDLE and HOLD.
REQ-019 In REQ or WAIT, an imem_valid=0 cycle SHALL go to or stay in WAIT.
REQ-020 In REQ or WAIT, imem_valid=1 with stall=0 SHALL load IF/ID with {PC, imem_rdata} and ifid_valid=1, set PC<=PC+4, and stay in REQ. This gives one-cycle fetch-to-IF/ID latency and one instruction per cycle at zero memory wait.
REQ-021 In REQ or WAIT, imem_valid=1 with stall=1 SHALL capture {PC, imem_rdata} in a one-entry skid buffer, hold IF/ID and PC, and go to HOLD.
REQ-022 In HOLD, stall=0 SHALL move the skid buffer into IF/ID (ifid_valid=1), set PC<=PC+4, and go to REQ; stall=1 SHALL remain in HOLD.
REQ-023 Any cycle with stall=1 and no redirect SHALL leave ifid_curr_pc, ifid_curr_instr and ifid_valid unchanged.
REQ-024 branch_taken=1 SHALL override stall and flush:
  - PC<={branch_target[8:2],2'b00}
  - IF/ID<={PC, NOP_INSTR}, ifid_valid=0
  - skid buffer emptied
  - next state REQ
REQ-025 If branch_taken arrives while a request is outstanding (WAIT, or REQ with imem_valid=0), the next imem_valid response SHALL be discarded via a drop flag, and the redirected address SHALL be requested after it.
REQ-026 flush=1 without branch_taken SHALL load IF/ID with NOP_INSTR and ifid_valid=0, while PC and FSM continue per REQ-020..022. An instruction accepted in the same cycle SHALL be dropped and its PC not advanced.

Reset
REQ-027 While reset=0, the block SHALL asynchronously set:
  - PC=RESET_PC, state IDLE, imem_req=0, imem_addr=RESET_PC
  - ifid_curr_pc=0, ifid_curr_instr=NOP_INSTR, ifid_valid=0
  - skid buffer and drop flag cleared
REQ-028 Reset asserted mid-request SHALL abandon the request; any imem_valid seen before the first REQ state SHALL be ignored.

Configuration
REQ-029 With FETCH_PERF_EN defined, the block SHALL add 16-bit outputs:
  - perf_fetched: increments per IF/ID load with ifid_valid=1
  - perf_stalled: increments per cycle with stall=1
  - both saturate at 16'hFFFF and reset to 0
REQ-030 Without FETCH_PERF_EN, those ports and counters SHALL not exist, and behaviour SHALL otherwise be identical.

Verification
REQ-031 Release reset, imem_valid tied 1, imem_rdata=PC-derived -> imem_addr 000,004,008 on consecutive cycles; IF/ID pc 000 appears one cycle after its request.
REQ-032 imem_valid low 3 cycles at addr 9'h010 -> imem_req/addr held 3 cycles; IF/ID loads pc 010 one cycle after imem_valid.
REQ-033 stall=1 for 2 cycles while imem_valid=1 at 9'h020 -> IF/ID frozen, FSM in HOLD, no request; after release IF/ID pc 020, then 024 requested.
REQ-034 branch_taken=1, target 9'h0A6, with stall=1 at the same time -> next imem_addr 9'h0A4, ifid_instr 32'h0000_0013, ifid_valid=0.
REQ-035 PC=9'h1FC, imem_valid=1 -> next imem_addr 9'h000.
REQ-036 reset pulsed low during WAIT -> outputs take reset values immediately; the late imem_valid is ignored; fetch restarts at RESET_PC.
